// File: rtl/spi_reg_arbiter.sv
// Arbitrates one register-bus port between a synchronised SPI slave and a clk-domain host.
// Define SPI_REG_ARB_TIMEOUT_EN to abort accesses that see no reg_ready within TIMEOUT cycles.
`timescale 1ns/1ps
module spi_reg_arbiter #(
   parameter int unsigned AW          = 8,
   parameter int unsigned DW          = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 15
) (
   input  logic          clk,
   input  logic          resetb,
   input  logic          spi_rdstb,
   input  logic          spi_wrstb,
   input  logic [AW-1:0] spi_addr,
   input  logic [DW-1:0] spi_wdata,
   output logic [DW-1:0] spi_rdata,
   output logic          spi_ovr,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          reg_sel,
   output logic          reg_we,
   output logic [AW-1:0] reg_addr,
   output logic [DW-1:0] reg_wdata,
   input  logic [DW-1:0] reg_rdata,
   input  logic          reg_ready,
   output logic          bus_err
);

`ifdef SPI_REG_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
   logic                   rd_prev, wr_prev;
   logic                   spi_pend, spi_renew, cap_we;
   logic [AW-1:0]          cap_addr;
   logic [DW-1:0]          cap_wdata;
   logic                   grant_spi, last_spi;
   logic [CW-1:0]          cnt;

   logic          rd_edge_c, wr_edge_c, any_edge_c;
   logic          timeout_c, done_c, spi_clr_c, grant_host_c;
   logic [DW-1:0] rdata_c;

   // Strobe synchronisers and rising-edge history
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rd_sync <= '0;
         wr_sync <= '0;
         rd_prev <= 1'b0;
         wr_prev <= 1'b0;
      end else begin
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], spi_rdstb};
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], spi_wrstb};
         rd_prev <= rd_sync[SYNC_STAGES-1];
         wr_prev <= wr_sync[SYNC_STAGES-1];
      end
   end

   assign rd_edge_c    = rd_sync[SYNC_STAGES-1] & ~rd_prev;
   assign wr_edge_c    = wr_sync[SYNC_STAGES-1] & ~wr_prev;
   assign any_edge_c   = rd_edge_c | wr_edge_c;
   assign timeout_c    = TO_EN && (state == ACCESS) && !reg_ready && (cnt == CW'(TIMEOUT - 1));
   assign done_c       = (state == ACCESS) && (reg_ready || timeout_c);
   assign spi_clr_c    = done_c && grant_spi;
   assign rdata_c      = timeout_c ? '1 : reg_rdata;
   assign grant_host_c = host_req && (last_spi || !spi_pend);

   // spi_renew marks a strobe that arrived after the SPI request now on the bus was granted
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state      <= IDLE;
         spi_pend   <= 1'b0;
         spi_renew  <= 1'b0;
         cap_we     <= 1'b0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         grant_spi  <= 1'b0;
         last_spi   <= 1'b0;
         cnt        <= '0;
         spi_rdata  <= '0;
         spi_ovr    <= 1'b0;
         host_ack   <= 1'b0;
         host_rdata <= '0;
         reg_sel    <= 1'b0;
         reg_we     <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         bus_err    <= 1'b0;
      end else begin
         host_ack <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (grant_host_c) begin
                  reg_addr  <= host_addr;
                  reg_we    <= host_we;
                  reg_wdata <= host_wdata;
                  grant_spi <= 1'b0;
                  reg_sel   <= 1'b1;
                  state     <= ACCESS;
               end else if (spi_pend) begin
                  reg_addr  <= cap_addr;
                  reg_we    <= cap_we;
                  reg_wdata <= cap_wdata;
                  grant_spi <= 1'b1;
                  spi_renew <= 1'b0;
                  reg_sel   <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (done_c) begin
                  reg_sel  <= 1'b0;
                  bus_err  <= timeout_c;
                  last_spi <= grant_spi;
                  state    <= DONE;
                  if (grant_spi) begin
                     spi_pend <= spi_renew;
                     if (!reg_we) spi_rdata <= rdata_c;
                  end else begin
                     host_ack <= 1'b1;
                     if (!reg_we) host_rdata <= rdata_c;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
         // A new strobe always wins over the clear above; a read beats a simultaneous write
         if (any_edge_c) begin
            spi_pend  <= 1'b1;
            spi_renew <= 1'b1;
            cap_addr  <= spi_addr;
            cap_wdata <= spi_wdata;
            cap_we    <= wr_edge_c & ~rd_edge_c;
            if ((spi_pend && !(spi_clr_c && !spi_renew)) || (rd_edge_c && wr_edge_c))
               spi_ovr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Self-checking bench for spi_reg_arbiter: bench-side register bank with wait states,
// bus-access log, and an array reference model of expected register contents.
`timescale 1ns/1ps
module tb_spi_reg_arbiter;
   localparam int unsigned AW = 8, DW = 8, TIMEOUT = 15;

   logic clk = 1'b0, resetb = 1'b0;
   logic spi_rdstb = 1'b0, spi_wrstb = 1'b0;
   logic [AW-1:0] spi_addr = '0, host_addr = '0, reg_addr;
   logic [DW-1:0] spi_wdata = '0, host_wdata = '0, spi_rdata, host_rdata, reg_wdata, reg_rdata;
   logic spi_ovr, host_req = 1'b0, host_we = 1'b0, host_ack, reg_sel, reg_we, reg_ready, bus_err;

   int unsigned passed = 0, total = 0;
   int ready_mode = 1, wait_n = 0, wcnt = 0, cyc = 0;
   logic sel_d = 1'b0;
   logic [DW-1:0] mem [256];
   logic [DW-1:0] model [256];

   typedef struct {logic we; logic [AW-1:0] a; logic [DW-1:0] d; int c;} acc_t;
   acc_t log_q[$];

   always #5 clk = ~clk;

   spi_reg_arbiter #(.AW(AW), .DW(DW), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .resetb(resetb), .spi_rdstb(spi_rdstb), .spi_wrstb(spi_wrstb),
      .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata), .spi_ovr(spi_ovr),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata), .reg_sel(reg_sel), .reg_we(reg_we),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .reg_ready(reg_ready), .bus_err(bus_err));

   // Register bank: mode 0 never ready, 1 always ready, 2 ready after wait_n wait cycles
   assign reg_ready = (ready_mode == 1) || (ready_mode == 2 && reg_sel && wcnt >= wait_n);
   assign reg_rdata = mem[reg_addr];

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      sel_d <= reg_sel;
      wcnt  <= reg_sel ? wcnt + 1 : 0;
      if (reg_sel && reg_we && reg_ready) mem[reg_addr] <= reg_wdata;
      if (reg_sel && !sel_d) log_q.push_back('{reg_we, reg_addr, reg_wdata, cyc});
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      resetb = 1'b0; host_req = 1'b0; spi_rdstb = 1'b0; spi_wrstb = 1'b0;
      ready_mode = 1; wait_n = 0;
      repeat (3) tick();
      resetb = 1'b1;
      tick();
      log_q.delete();
   endtask

   task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output bit ok);
      host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1; ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (host_ack) begin ok = 1'b1; break; end
      end
      rd = host_rdata;
      host_req = 1'b0;
   endtask

   task automatic spi_op(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      spi_addr = a; spi_wdata = d;
      if (rd) spi_rdstb = 1'b1; else spi_wrstb = 1'b1;
      repeat (4) tick();
      spi_rdstb = 1'b0; spi_wrstb = 1'b0;
      repeat (4) tick();
   endtask

   task automatic wait_quiet(output bit ok);
      int q = 0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         q = reg_sel ? 0 : q + 1;
         if (q >= 4) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_sel(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (reg_sel) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      resetb = 1'b0; ready_mode = 0;
      #3;
      total++; if ({reg_sel, reg_we, reg_addr, reg_wdata} !== '0)
         $display("FAIL reset_regbus: got %h want 0", {reg_sel, reg_we, reg_addr, reg_wdata}); else passed++;
      total++; if ({host_ack, host_rdata, bus_err} !== '0)
         $display("FAIL reset_host: got %h want 0", {host_ack, host_rdata, bus_err}); else passed++;
      total++; if ({spi_rdata, spi_ovr} !== '0)
         $display("FAIL reset_spi: got %h want 0", {spi_rdata, spi_ovr}); else passed++;
      do_reset();
      total++; if (reg_sel !== 1'b0) $display("FAIL reset_idle_sel: got %b want 0", reg_sel); else passed++;
   endtask

   task automatic test_host_write();
      logic [DW-1:0] rd, exp_hrd;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit ok, we;
      do_reset();
      host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A; host_req = 1'b1;
      tick();
      total++; if ({reg_sel, reg_we, reg_addr, reg_wdata} !== {1'b1, 1'b1, 8'h10, 8'h5A})
         $display("FAIL t1_regbus_n1: got %h want %h", {reg_sel, reg_we, reg_addr, reg_wdata}, {1'b1, 1'b1, 8'h10, 8'h5A}); else passed++;
      total++; if (host_ack !== 1'b0) $display("FAIL t1_ack_n1: got %b want 0", host_ack); else passed++;
      tick();
      total++; if ({host_ack, reg_sel} !== 2'b10)
         $display("FAIL t1_ack_n2: got %b want 10", {host_ack, reg_sel}); else passed++;
      host_req = 1'b0;
      tick();
      total++; if (host_ack !== 1'b0) $display("FAIL t1_ack_pulse: got %b want 0", host_ack); else passed++;
      model[8'h10] = 8'h5A;
      exp_hrd = '0;
      // Writes then reads to a few addresses with random wait states
      ready_mode = 2;
      for (int i = 0; i < 8; i++) begin
         wait_n = int'($urandom_range(0, 3));
         a = 8'(8'h10 + (i % 4) * 3);
         we = (i < 4);
         d = 8'($urandom);
         host_op(we, a, d, rd, ok);
         total++; if (!ok) $display("FAIL host_op_timeout: got no ack want ack i=%0d", i); else passed++;
         if (we) model[a] = d; else exp_hrd = model[a];
         total++; if (rd !== exp_hrd) $display("FAIL host_rdata: got %h want %h addr %h", rd, exp_hrd, a); else passed++;
      end
      repeat (2) tick();
      total++; if (host_rdata !== exp_hrd) $display("FAIL host_rdata_held: got %h want %h", host_rdata, exp_hrd); else passed++;
   endtask

   task automatic test_spi_read();
      logic [DW-1:0] rd;
      bit ok, ack_seen, fin, was_sel;
      int selc, n0;
      ready_mode = 1;
      host_op(1'b1, 8'h22, 8'hC3, rd, ok);
      model[8'h22] = 8'hC3;
      ready_mode = 2; wait_n = 3;
      n0 = log_q.size();
      spi_addr = 8'h22; spi_rdstb = 1'b1;
      selc = 0; ack_seen = 0; fin = 0; was_sel = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (i == 4) spi_rdstb = 1'b0;
         if (host_ack) ack_seen = 1;
         if (reg_sel) begin
            if (!was_sel) begin
               total++; if ({reg_we, reg_addr} !== {1'b0, 8'h22})
                  $display("FAIL t2_regbus: got %h want %h", {reg_we, reg_addr}, {1'b0, 8'h22}); else passed++;
            end
            selc++; was_sel = 1;
         end else if (was_sel) begin
            fin = 1;
            total++; if (spi_rdata !== 8'hC3) $display("FAIL t2_spi_rdata: got %h want c3", spi_rdata); else passed++;
            break;
         end
      end
      spi_rdstb = 1'b0;
      total++; if (!fin) $display("FAIL t2_complete: got none want access"); else passed++;
      total++; if (selc !== 4) $display("FAIL t2_sel_cycles: got %0d want 4", selc); else passed++;
      repeat (10) tick();
      total++; if (ack_seen || host_ack) $display("FAIL t2_no_ack: got ack want none"); else passed++;
      total++; if (log_q.size() !== n0 + 1) $display("FAIL t2_pend_clear: got %0d accesses want %0d", log_q.size() - n0, 1); else passed++;
   endtask

   task automatic test_alternation();
      logic [AW-1:0] a1, a2, a3;
      logic [DW-1:0] d1, d2, d3, rd;
      bit ok;
      do_reset();
      a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
      d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
      ready_mode = 0;
      spi_addr = a1; spi_wdata = d1; spi_wrstb = 1'b1;
      wait_sel(ok);
      total++; if (!ok) $display("FAIL t3_spi1_grant: got none want grant"); else passed++;
      spi_wrstb = 1'b0;
      repeat (4) tick();
      host_we = 1'b1; host_addr = a2; host_wdata = d2; host_req = 1'b1;
      spi_op(1'b0, a3, d3);
      ready_mode = 1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (host_ack) begin ok = 1; break; end
      end
      host_req = 1'b0;
      total++; if (!ok) $display("FAIL t3_host_ack: got none want ack"); else passed++;
      wait_quiet(ok);
      model[a1] = d1; model[a2] = d2; model[a3] = d3;
      total++; if (log_q.size() !== 3) $display("FAIL t3_count: got %0d want 3", log_q.size()); else passed++;
      if (log_q.size() == 3) begin
         total++; if ({log_q[0].we, log_q[0].a, log_q[0].d} !== {1'b1, a1, d1})
            $display("FAIL t3_first: got %h want %h", {log_q[0].we, log_q[0].a, log_q[0].d}, {1'b1, a1, d1}); else passed++;
         total++; if ({log_q[1].we, log_q[1].a, log_q[1].d} !== {1'b1, a2, d2})
            $display("FAIL t3_host_second: got %h want %h", {log_q[1].we, log_q[1].a, log_q[1].d}, {1'b1, a2, d2}); else passed++;
         total++; if ({log_q[2].we, log_q[2].a, log_q[2].d} !== {1'b1, a3, d3})
            $display("FAIL t3_spi_third: got %h want %h", {log_q[2].we, log_q[2].a, log_q[2].d}, {1'b1, a3, d3}); else passed++;
         total++; if (log_q[2].c - log_q[1].c !== 3)
            $display("FAIL t3_back_to_back: got gap %0d want 3", log_q[2].c - log_q[1].c); else passed++;
      end
      host_op(1'b0, a3, 8'h00, rd, ok);
      total++; if (rd !== model[a3]) $display("FAIL t3_readback: got %h want %h", rd, model[a3]); else passed++;
   endtask

   task automatic test_overrun();
      logic [AW-1:0] ah, a1, a2;
      logic [DW-1:0] dh, d1, d2;
      bit ok;
      do_reset();
      total++; if (spi_ovr !== 1'b0) $display("FAIL t4_ovr_init: got %b want 0", spi_ovr); else passed++;
      ah = 8'($urandom); dh = 8'($urandom);
      a1 = 8'($urandom); a2 = a1 ^ 8'h05; d1 = 8'($urandom); d2 = 8'($urandom);
      ready_mode = 0;
      host_we = 1'b1; host_addr = ah; host_wdata = dh; host_req = 1'b1;
      wait_sel(ok);
      spi_op(1'b0, a1, d1);
      total++; if (spi_ovr !== 1'b0) $display("FAIL t4_ovr_single: got %b want 0", spi_ovr); else passed++;
      spi_op(1'b0, a2, d2);
      total++; if (spi_ovr !== 1'b1) $display("FAIL t4_ovr_set: got %b want 1", spi_ovr); else passed++;
      ready_mode = 1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (host_ack) begin ok = 1; break; end
      end
      host_req = 1'b0;
      wait_quiet(ok);
      model[ah] = dh; model[a2] = d2;
      total++; if (log_q.size() !== 2) $display("FAIL t4_count: got %0d want 2", log_q.size()); else passed++;
      if (log_q.size() == 2) begin
         total++; if ({log_q[1].we, log_q[1].a, log_q[1].d} !== {1'b1, a2, d2})
            $display("FAIL t4_second_only: got %h want %h", {log_q[1].we, log_q[1].a, log_q[1].d}, {1'b1, a2, d2}); else passed++;
      end
      repeat (5) tick();
      total++; if (spi_ovr !== 1'b1) $display("FAIL t4_ovr_sticky: got %b want 1", spi_ovr); else passed++;
   endtask

   task automatic test_reset_mid();
      bit ok, seen;
      int n0;
      ready_mode = 0;
      host_we = 1'b1; host_addr = 8'($urandom); host_wdata = 8'($urandom); host_req = 1'b1;
      wait_sel(ok);
      n0 = log_q.size();
      resetb = 1'b0; host_req = 1'b0;
      #1;
      total++; if ({reg_sel, reg_we, reg_addr, reg_wdata, host_ack, host_rdata, spi_rdata, spi_ovr, bus_err} !== '0)
         $display("FAIL t5_async_reset: got %h want 0",
                  {reg_sel, reg_we, reg_addr, reg_wdata, host_ack, host_rdata, spi_rdata, spi_ovr, bus_err}); else passed++;
      repeat (2) tick();
      resetb = 1'b1; ready_mode = 1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (host_ack || reg_sel) seen = 1;
      end
      total++; if (seen) $display("FAIL t5_no_ack: got activity want none"); else passed++;
      total++; if (log_q.size() !== n0) $display("FAIL t5_no_access: got %0d want %0d", log_q.size(), n0); else passed++;
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      logic [DW-1:0] d, rd, exp_srd;
      bit ok, use_spi, we;
      do_reset();
      exp_srd = '0;
      ready_mode = 2;
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         host_op(1'b1, 8'(8'h40 + i * 5), d, rd, ok);
         model[8'(8'h40 + i * 5)] = d;
      end
      for (int i = 0; i < 12; i++) begin
         wait_n = int'($urandom_range(0, 3));
         a = 8'(8'h40 + $urandom_range(0, 7) * 5);
         d = 8'($urandom);
         use_spi = 1'($urandom);
         we = 1'($urandom);
         if (use_spi) begin
            spi_op(!we, a, d);
            wait_quiet(ok);
            total++; if (!ok) $display("FAIL rnd_spi_quiet: got busy want idle i=%0d", i); else passed++;
            if (we) model[a] = d; else exp_srd = model[a];
            total++; if (spi_rdata !== exp_srd) $display("FAIL rnd_spi_rdata: got %h want %h i=%0d", spi_rdata, exp_srd, i); else passed++;
         end else begin
            host_op(we, a, d, rd, ok);
            if (we) model[a] = d;
            else begin
               total++; if (rd !== model[a]) $display("FAIL rnd_host_rdata: got %h want %h i=%0d", rd, model[a], i); else passed++;
            end
         end
      end
   endtask

`ifdef SPI_REG_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int selc;
      bit ok;
      do_reset();
      ready_mode = 0;
      host_we = 1'b0; host_addr = 8'($urandom); host_req = 1'b1;
      selc = 0; ok = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (reg_sel) selc++;
         if (host_ack) begin ok = 1; break; end
      end
      total++; if (!ok) $display("FAIL t6_ack: got none want ack"); else passed++;
      total++; if (selc !== TIMEOUT) $display("FAIL t6_cycles: got %0d want %0d", selc, TIMEOUT); else passed++;
      total++; if (bus_err !== 1'b1) $display("FAIL t6_bus_err: got %b want 1", bus_err); else passed++;
      total++; if (host_rdata !== 8'hFF) $display("FAIL t6_rdata: got %h want ff", host_rdata); else passed++;
      host_req = 1'b0;
      tick();
      total++; if (bus_err !== 1'b0) $display("FAIL t6_err_pulse: got %b want 0", bus_err); else passed++;
      ready_mode = 1;
   endtask
`endif

   initial begin
      test_reset();
      test_host_write();
      test_spi_read();
      test_alternation();
      test_overrun();
      test_reset_mid();
      test_random();
`ifdef SPI_REG_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
